// File: rtl/matrix_pkg.sv
// Shared types and sizing helpers for the matrix multiply-accumulate block.
package matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MAC    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Index counters need at least one bit even for tiny N.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // N products of two ENTRY_SIZE-bit values sum without overflow in this width.
    function automatic int acc_width(input int entry_size, input int n);
        return 2 * entry_size + $clog2(n);
    endfunction

    localparam int DEFAULT_N     = 3;
    localparam int DEFAULT_IDX_W = idx_width(DEFAULT_N);

endpackage

// File: rtl/matrix_mac_multiplier_mac_unit.sv
// Combinational multiply-accumulate: sum = a*b + (clear ? 0 : acc_in).
module mac_unit
    import matrix_pkg::*;
#(
    parameter int ENTRY_SIZE = 5,
    parameter int ACC_W      = acc_width(5, DEFAULT_N)
) (
    input  logic [ENTRY_SIZE-1:0] a,
    input  logic [ENTRY_SIZE-1:0] b,
    input  logic [ACC_W-1:0]      acc_in,
    input  logic                  clear,
    output logic [ACC_W-1:0]      sum
);

    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] base;

    assign prod = ACC_W'(a) * ACC_W'(b);
    assign base = clear ? '0 : acc_in;
    assign sum  = prod + base;

endmodule

// File: rtl/matrix_mac_multiplier.sv
// NxN unsigned matrix multiplier C = A x B on one time-shared MAC, N^3 MAC cycles
// plus one FINISH cycle; start/busy/done handshake, c_out updated atomically.
module matrix_mac_multiplier
    import matrix_pkg::*;
#(
    parameter int N             = 3,
    parameter int ENTRY_SIZE    = 5,
    parameter int RESENTRY_SIZE = ENTRY_SIZE,
    parameter int SATURATE      = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            a_wrenable,
    input  logic                            b_wrenable,
    input  logic [N*N*ENTRY_SIZE-1:0]       a_in,
    input  logic [N*N*ENTRY_SIZE-1:0]       b_in,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [N*N*RESENTRY_SIZE-1:0]    c_out
);

    localparam int ACC_W = acc_width(ENTRY_SIZE, N);
    localparam int IW    = idx_width(N);
    localparam int NN    = N * N;
    localparam int AW    = $clog2(NN);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [ENTRY_SIZE-1:0]    a_mem [NN];
    logic [ENTRY_SIZE-1:0]    b_mem [NN];
    logic [RESENTRY_SIZE-1:0] c_buf [NN];

    state_t             state;
    logic [IW-1:0]      i, j, k;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   mac_sum;
    logic [AW-1:0]      a_idx, b_idx, c_idx;
    logic [RESENTRY_SIZE-1:0] reduced;

    assign a_idx = AW'(i) * AW'(N) + AW'(k);
    assign b_idx = AW'(k) * AW'(N) + AW'(j);
    assign c_idx = AW'(i) * AW'(N) + AW'(j);

    mac_unit #(
        .ENTRY_SIZE (ENTRY_SIZE),
        .ACC_W      (ACC_W)
    ) u_mac (
        .a      (a_mem[a_idx]),
        .b      (b_mem[b_idx]),
        .acc_in (acc),
        .clear  (k == '0),
        .sum    (mac_sum)
    );

    generate
        if (SATURATE != 0 && ACC_W > RESENTRY_SIZE) begin : g_sat
            assign reduced = (mac_sum > ACC_W'({RESENTRY_SIZE{1'b1}})) ? '1
                                                                         : mac_sum[RESENTRY_SIZE-1:0];
        end else if (ACC_W > RESENTRY_SIZE) begin : g_trunc
            assign reduced = mac_sum[RESENTRY_SIZE-1:0];
        end else begin : g_ext
            assign reduced = RESENTRY_SIZE'(mac_sum);
        end
    endgenerate

    // Operand banks are frozen for the whole run, FINISH included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < NN; e++) begin
                a_mem[e] <= '0;
                b_mem[e] <= '0;
            end
        end else if (state == ST_IDLE) begin
            if (a_wrenable) begin
                for (int e = 0; e < NN; e++) a_mem[e] <= a_in[e*ENTRY_SIZE +: ENTRY_SIZE];
            end
            if (b_wrenable) begin
                for (int e = 0; e < NN; e++) b_mem[e] <= b_in[e*ENTRY_SIZE +: ENTRY_SIZE];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            c_out <= '0;
            for (int e = 0; e < NN; e++) c_buf[e] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_MAC;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_MAC: begin
                    acc <= mac_sum;
                    if (k == LAST) begin
                        c_buf[c_idx] <= reduced;
                        k <= '0;
                        if (j == LAST) begin
                            j <= '0;
                            if (i == LAST) begin
                                i     <= '0;
                                state <= ST_FINISH;
                            end else begin
                                i <= i + 1'b1;
                            end
                        end else begin
                            j <= j + 1'b1;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_FINISH: begin
                    for (int e = 0; e < NN; e++) c_out[e*RESENTRY_SIZE +: RESENTRY_SIZE] <= c_buf[e];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mac_multiplier.sv
// Bench for matrix_mac_multiplier: two 3x3 instances (truncate/saturate) sharing inputs, one 2x2.
module tb_matrix_mac_multiplier;

    localparam int N3 = 3, E = 5, R3 = 5, N2 = 2, R2 = 8;
    localparam int W3 = N3*N3*E, C3 = N3*N3*R3, W2 = N2*N2*E, C2 = N2*N2*R2;

    logic clk = 1'b0;
    logic reset;
    logic a_we0, b_we0, start0;
    logic [W3-1:0] a_in0, b_in0;
    logic busy0, done0, busy1, done1;
    logic [C3-1:0] c_out0, c_out1;
    logic a_we2, b_we2, start2;
    logic [W2-1:0] a_in2, b_in2;
    logic busy2, done2;
    logic [C2-1:0] c_out2;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    matrix_mac_multiplier #(.N(N3), .ENTRY_SIZE(E), .RESENTRY_SIZE(R3), .SATURATE(0)) u0 (
        .clk(clk), .reset(reset), .a_wrenable(a_we0), .b_wrenable(b_we0),
        .a_in(a_in0), .b_in(b_in0), .start(start0),
        .busy(busy0), .done(done0), .c_out(c_out0));

    matrix_mac_multiplier #(.N(N3), .ENTRY_SIZE(E), .RESENTRY_SIZE(R3), .SATURATE(1)) u1 (
        .clk(clk), .reset(reset), .a_wrenable(a_we0), .b_wrenable(b_we0),
        .a_in(a_in0), .b_in(b_in0), .start(start0),
        .busy(busy1), .done(done1), .c_out(c_out1));

    matrix_mac_multiplier #(.N(N2), .ENTRY_SIZE(E), .RESENTRY_SIZE(R2), .SATURATE(0)) u2 (
        .clk(clk), .reset(reset), .a_wrenable(a_we2), .b_wrenable(b_we2),
        .a_in(a_in2), .b_in(b_in2), .start(start2),
        .busy(busy2), .done(done2), .c_out(c_out2));

    // Reference: plain dot products, then modulo or clamp to the result width.
    function automatic logic [127:0] model(input logic [127:0] a, input logic [127:0] b,
                                           input int n, input int e, input int r, input bit sat);
        logic [127:0] c;
        longint s, lim, x, y;
        c = '0;
        lim = longint'(1) << r;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) begin
                    x = longint'((a >> ((i*n+k)*e)) & ((128'd1 << e) - 128'd1));
                    y = longint'((b >> ((k*n+j)*e)) & ((128'd1 << e) - 128'd1));
                    s += x * y;
                end
                if (sat) s = (s > lim - 1) ? lim - 1 : s;
                else     s = s % lim;
                c = c | (128'(s) << ((i*n+j)*r));
            end
        end
        return c;
    endfunction

    function automatic logic [W3-1:0] rnd3();
        return W3'({$urandom(), $urandom()});
    endfunction

    // Called #1 after an edge; returns edges from start sample to done (-1 on timeout).
    task automatic run_u0(input logic [W3-1:0] a, input logic [W3-1:0] b, input bit wr,
                          output int lat, output int busy_cycles, output bit changed);
        logic [C3-1:0] c_prev;
        c_prev = c_out0;
        a_in0 = a; b_in0 = b; a_we0 = wr; b_we0 = wr; start0 = 1'b1;
        @(posedge clk); #1;
        a_we0 = 1'b0; b_we0 = 1'b0; start0 = 1'b0;
        busy_cycles = int'(busy0);
        lat = -1;
        changed = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (busy0) busy_cycles++;
            if (done0) begin
                lat = n;
                break;
            end
            if (c_out0 !== c_prev) changed = 1'b1;
        end
    endtask

    task automatic run_u2(input logic [W2-1:0] a, input logic [W2-1:0] b, output int lat);
        a_in2 = a; b_in2 = b; a_we2 = 1'b1; b_we2 = 1'b1; start2 = 1'b1;
        @(posedge clk); #1;
        a_we2 = 1'b0; b_we2 = 1'b0; start2 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk); #1;
            if (done2) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
        n_cmp++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
        n_cmp++; if (c_out0 !== '0) begin n_fail++; $display("FAIL reset_c0: got %h want 0", c_out0); end
        n_cmp++; if (c_out1 !== '0) begin n_fail++; $display("FAIL reset_c1: got %h want 0", c_out1); end
        n_cmp++; if (c_out2 !== '0 || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_u2: got c=%h busy=%b want 0/0", c_out2, busy2);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_identity();
        int bv[9] = '{1, 2, 3, 8, 9, 10, 15, 16, 17};
        logic [W3-1:0] a, b;
        int lat, bc;
        bit ch;
        a = '0; b = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                a[(r*3+c)*E +: E] = (r == c) ? 5'd1 : 5'd0;
                b[(r*3+c)*E +: E] = 5'(bv[r*3+c]);
            end
        run_u0(a, b, 1'b1, lat, bc, ch);
        n_cmp++; if (lat != 28) begin n_fail++; $display("FAIL ident_latency: got %0d want 28", lat); end
        n_cmp++; if (bc != 28) begin n_fail++; $display("FAIL ident_busy_cycles: got %0d want 28", bc); end
        n_cmp++; if (ch) begin n_fail++; $display("FAIL ident_partial: got c_out change mid-run want none"); end
        n_cmp++; if (c_out0 !== b) begin n_fail++; $display("FAIL ident_result: got %h want %h", c_out0, b); end
        n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL ident_busy_at_done: got %b want 0", busy0); end
        @(posedge clk); #1;
        n_cmp++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL ident_done_pulse: got %b want 0", done0); end
    endtask

    task automatic test_2x2();
        logic [W2-1:0] a, b;
        logic [C2-1:0] want;
        int lat;
        a = {5'd4, 5'd3, 5'd2, 5'd1};
        b = {5'd8, 5'd7, 5'd6, 5'd5};
        want = {8'd50, 8'd43, 8'd22, 8'd19};
        run_u2(a, b, lat);
        n_cmp++; if (lat != 9) begin n_fail++; $display("FAIL 2x2_latency: got %0d want 9", lat); end
        n_cmp++; if (c_out2 !== want) begin n_fail++; $display("FAIL 2x2_result: got %h want %h", c_out2, want); end
    endtask

    task automatic test_overflow();
        logic [W3-1:0] a;
        logic [C3-1:0] w0, w1;
        int lat, bc;
        bit ch;
        a = '1;
        for (int e = 0; e < 9; e++) begin
            w0[e*R3 +: R3] = 5'd3;
            w1[e*R3 +: R3] = 5'd31;
        end
        run_u0(a, a, 1'b1, lat, bc, ch);
        n_cmp++; if (c_out0 !== w0) begin n_fail++; $display("FAIL ovf_truncate: got %h want %h", c_out0, w0); end
        n_cmp++; if (c_out1 !== w1) begin n_fail++; $display("FAIL ovf_saturate: got %h want %h", c_out1, w1); end
        n_cmp++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL ovf_sat_done: got %b want 1", done1); end
    endtask

    task automatic test_random();
        logic [W3-1:0] a, b;
        logic [W2-1:0] a2, b2;
        logic [127:0] e0, e1, e2;
        int lat, bc;
        bit ch;
        for (int t = 0; t < 6; t++) begin
            a = rnd3(); b = rnd3();
            run_u0(a, b, 1'b1, lat, bc, ch);
            e0 = model(128'(a), 128'(b), N3, E, R3, 1'b0);
            e1 = model(128'(a), 128'(b), N3, E, R3, 1'b1);
            n_cmp++; if (c_out0 !== e0[C3-1:0] || lat != 28) begin
                n_fail++; $display("FAIL rand_trunc[%0d]: got %h lat %0d want %h lat 28", t, c_out0, lat, e0[C3-1:0]);
            end
            n_cmp++; if (c_out1 !== e1[C3-1:0]) begin
                n_fail++; $display("FAIL rand_sat[%0d]: got %h want %h", t, c_out1, e1[C3-1:0]);
            end
            a2 = W2'($urandom()); b2 = W2'($urandom());
            run_u2(a2, b2, lat);
            e2 = model(128'(a2), 128'(b2), N2, E, R2, 1'b0);
            n_cmp++; if (c_out2 !== e2[C2-1:0] || lat != 9) begin
                n_fail++; $display("FAIL rand_2x2[%0d]: got %h lat %0d want %h lat 9", t, c_out2, lat, e2[C2-1:0]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        logic [W3-1:0] a, b;
        logic [127:0] e0;
        int ndone, first, lat, bc;
        bit ch;
        a = rnd3(); b = rnd3();
        e0 = model(128'(a), 128'(b), N3, E, R3, 1'b0);
        a_in0 = a; b_in0 = b; a_we0 = 1'b1; b_we0 = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        a_we0 = 1'b0; b_we0 = 1'b0; start0 = 1'b0;
        ndone = 0; first = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done0) begin
                ndone++;
                if (first < 0) first = n;
            end
            if (n == 5) begin
                start0 = 1'b1; a_we0 = 1'b1; b_we0 = 1'b1; a_in0 = '0; b_in0 = '0;
            end
            if (n == 6) begin
                start0 = 1'b0; a_we0 = 1'b0; b_we0 = 1'b0;
            end
        end
        n_cmp++; if (ndone != 1 || first != 28) begin
            n_fail++; $display("FAIL busy_ignore_done: got %0d pulses first at %0d want 1 at 28", ndone, first);
        end
        n_cmp++; if (c_out0 !== e0[C3-1:0]) begin
            n_fail++; $display("FAIL busy_ignore_result: got %h want %h", c_out0, e0[C3-1:0]);
        end
        run_u0('0, '0, 1'b0, lat, bc, ch);
        n_cmp++; if (c_out0 !== e0[C3-1:0] || lat != 28) begin
            n_fail++; $display("FAIL busy_ignore_rerun: got %h lat %0d want %h lat 28", c_out0, lat, e0[C3-1:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [W3-1:0] a, b;
        logic [127:0] e0;
        int ndone, lat, bc;
        bit ch;
        a = rnd3(); b = rnd3();
        e0 = model(128'(a), 128'(b), N3, E, R3, 1'b0);
        a_in0 = a; b_in0 = b; a_we0 = 1'b1; b_we0 = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        a_we0 = 1'b0; b_we0 = 1'b0; start0 = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (busy0 !== 1'b0 || done0 !== 1'b0 || c_out0 !== '0) begin
            n_fail++; $display("FAIL midreset_clear: got busy=%b done=%b c=%h want 0/0/0", busy0, done0, c_out0);
        end
        @(posedge clk); #1 reset = 1'b0;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done0 || busy0) ndone++;
        end
        n_cmp++; if (ndone != 0) begin n_fail++; $display("FAIL midreset_quiet: got %0d active cycles want 0", ndone); end
        run_u0(a, b, 1'b1, lat, bc, ch);
        n_cmp++; if (c_out0 !== e0[C3-1:0] || lat != 28) begin
            n_fail++; $display("FAIL midreset_rerun: got %h lat %0d want %h lat 28", c_out0, lat, e0[C3-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [W3-1:0] a1, b1, a2, b2;
        logic [127:0] e1, e2;
        int lat1, lat2, bc;
        bit ch;
        a1 = rnd3(); b1 = rnd3(); a2 = rnd3(); b2 = rnd3();
        e1 = model(128'(a1), 128'(b1), N3, E, R3, 1'b0);
        e2 = model(128'(a2), 128'(b2), N3, E, R3, 1'b0);
        run_u0(a1, b1, 1'b1, lat1, bc, ch);
        n_cmp++; if (c_out0 !== e1[C3-1:0] || lat1 != 28) begin
            n_fail++; $display("FAIL b2b_first: got %h lat %0d want %h lat 28", c_out0, lat1, e1[C3-1:0]);
        end
        run_u0(a2, b2, 1'b1, lat2, bc, ch);
        n_cmp++; if (lat2 + 1 != 29) begin n_fail++; $display("FAIL b2b_gap: got %0d edges want 29", lat2 + 1); end
        n_cmp++; if (ch) begin n_fail++; $display("FAIL b2b_hold: got c_out change between done pulses want none"); end
        n_cmp++; if (c_out0 !== e2[C3-1:0]) begin
            n_fail++; $display("FAIL b2b_second: got %h want %h", c_out0, e2[C3-1:0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        a_we0 = 1'b0; b_we0 = 1'b0; start0 = 1'b0; a_in0 = '0; b_in0 = '0;
        a_we2 = 1'b0; b_we2 = 1'b0; start2 = 1'b0; a_in2 = '0; b_in2 = '0;
        test_reset();
        test_identity();
        test_2x2();
        test_overflow();
        test_random();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
